// File: rtl/branch_target_predictor.sv
// Next-PC predictor for the fetch stage: direct-mapped BTB with 2-bit counters,
// trained by branch/JAL resolution in EX, plus resolution/mispredict statistics.
module branch_target_predictor #(
  parameter int DBITS    = 32,
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = DBITS - IDX_BITS - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] fetch_pc,
  output logic             pred_taken,
  output logic [DBITS-1:0] pred_next_pc,
  input  logic             ex_valid,
  input  logic [DBITS-1:0] ex_pc,
  input  logic             ex_pred_taken,
  input  logic [DBITS-1:0] ex_pred_target,
  input  logic             ex_taken,
  input  logic [DBITS-1:0] ex_target,
  output logic             mispredict,
  output logic [DBITS-1:0] recover_pc,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [DBITS-1:0]    target_q [ENTRIES];
  logic [1:0]          cnt_q    [ENTRIES];

  logic [31:0] branches_q, branches_d;
  logic [31:0] mispredicts_q, mispredicts_d;

  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic                fetch_hit;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;

  logic                upd_en;
  logic [DBITS-1:0]    upd_target;
  logic [1:0]          upd_cnt;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = fetch_pc[DBITS-1:IDX_BITS+2];
  assign ex_idx    = ex_pc[IDX_BITS+1:2];
  assign ex_tag    = ex_pc[DBITS-1:IDX_BITS+2];

  // Lookup reads the stored array directly, so a same-cycle update is not visible yet.
  assign fetch_hit    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken   = fetch_hit && cnt_q[fetch_idx][1];
  assign pred_next_pc = pred_taken ? target_q[fetch_idx] : fetch_pc + DBITS'(4);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign mispredict = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
  assign recover_pc = ex_taken ? ex_target : ex_pc + DBITS'(4);

  always_comb begin
    upd_en     = 1'b0;
    upd_target = target_q[ex_idx];
    upd_cnt    = cnt_q[ex_idx];
    if (ex_valid) begin
      if (ex_hit) begin
        upd_en = 1'b1;
        if (ex_taken) begin
          upd_target = ex_target;
          upd_cnt    = (cnt_q[ex_idx] == 2'd3) ? 2'd3 : cnt_q[ex_idx] + 2'd1;
        end else begin
          upd_cnt    = (cnt_q[ex_idx] == 2'd0) ? 2'd0 : cnt_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        // A taken miss evicts whatever shares the index and starts weakly taken.
        upd_en     = 1'b1;
        upd_target = ex_target;
        upd_cnt    = 2'd2;
      end
    end
  end

  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (ex_valid) begin
      branches_d = branches_q + 32'd1;
    end
    if (mispredict) begin
      mispredicts_d = mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'd1;
      end
    end else if (upd_en) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= upd_target;
      cnt_q[ex_idx]    <= upd_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: hand-computed vectors covering
// allocation, counter training, aliasing, same-cycle hazard, wrap and reset.
module tb_branch_target_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        mispredict;
  logic [31:0] recover_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int vectorCount = 0;
  int missCount   = 0;

  branch_target_predictor #(.DBITS(32), .IDX_BITS(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_pc         (fetch_pc),
    .pred_taken       (pred_taken),
    .pred_next_pc     (pred_next_pc),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .mispredict       (mispredict),
    .recover_pc       (recover_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge and settle before checks.
  task automatic applyStimulus(input logic [31:0] fpc, input logic v, input logic [31:0] pc,
                               input logic pt, input logic [31:0] ptgt,
                               input logic t, input logic [31:0] tgt);
    fetch_pc       = fpc;
    ex_valid       = v;
    ex_pc          = pc;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
    ex_taken       = t;
    ex_target      = tgt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("rst_next_pc", pred_next_pc, 32'h44);
    checkOutput("rst_branches", stat_branches, 32'd0);
    checkOutput("rst_mispredicts", stat_mispredicts, 32'd0);
    checkOutput("idle_mispredict", {31'd0, mispredict}, 32'd0);

    // Taken miss allocates 0x48 -> 0x80
    applyStimulus(32'h40, 1'b1, 32'h48, 1'b0, 32'h4C, 1'b1, 32'h80);
    checkOutput("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("alloc_recover", recover_pc, 32'h80);
    tick();
    applyStimulus(32'h48, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
    checkOutput("alloc_next_pc", pred_next_pc, 32'h80);
    checkOutput("alloc_mispredicts", stat_mispredicts, 32'd1);

    // Not taken twice: cnt 2->1 then 1->0
    applyStimulus(32'h48, 1'b1, 32'h48, 1'b1, 32'h80, 1'b0, 32'h80);
    checkOutput("nt1_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("nt1_recover", recover_pc, 32'h4C);
    tick();
    applyStimulus(32'h48, 1'b1, 32'h48, 1'b0, 32'h4C, 1'b0, 32'h80);
    checkOutput("nt2_live_pred", {31'd0, pred_taken}, 32'd0);
    checkOutput("nt2_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    applyStimulus(32'h48, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("nt_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("nt_next_pc", pred_next_pc, 32'h4C);
    checkOutput("nt_branches", stat_branches, 32'd3);
    checkOutput("nt_mispredicts", stat_mispredicts, 32'd2);

    // Retrain 0x48 taken: cnt 0->1->2, both cycles mispredicted (live pred not-taken)
    applyStimulus(32'h48, 1'b1, 32'h48, 1'b0, 32'h4C, 1'b1, 32'h80);
    tick();
    applyStimulus(32'h48, 1'b1, 32'h48, 1'b0, 32'h4C, 1'b1, 32'h80);
    checkOutput("retrain_weak_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    applyStimulus(32'h48, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("retrain_next_pc", pred_next_pc, 32'h80);

    // Aliasing: 0x88 shares index 2 with 0x48 and evicts it
    applyStimulus(32'h88, 1'b1, 32'h88, 1'b0, 32'h8C, 1'b1, 32'hC0);
    checkOutput("alias_before_next_pc", pred_next_pc, 32'h8C);
    tick();
    applyStimulus(32'h48, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("alias_48_next_pc", pred_next_pc, 32'h4C);
    applyStimulus(32'h88, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("alias_88_next_pc", pred_next_pc, 32'hC0);

    // Reallocate 0x48 -> 0x80, then same-cycle update to 0x100
    applyStimulus(32'h48, 1'b1, 32'h48, 1'b0, 32'h4C, 1'b1, 32'h80);
    tick();
    applyStimulus(32'h48, 1'b1, 32'h48, 1'b1, 32'h80, 1'b1, 32'h100);
    checkOutput("hazard_old_next_pc", pred_next_pc, 32'h80);
    checkOutput("hazard_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("hazard_recover", recover_pc, 32'h100);
    tick();
    applyStimulus(32'h48, 1'b1, 32'h48, 1'b1, 32'h100, 1'b1, 32'h100);
    checkOutput("hazard_new_next_pc", pred_next_pc, 32'h100);
    checkOutput("correct_mispredict", {31'd0, mispredict}, 32'd0);
    tick();

    // Taken with wrong predicted target
    applyStimulus(32'h48, 1'b1, 32'h200, 1'b1, 32'h80, 1'b1, 32'h90);
    checkOutput("tgt_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("tgt_recover", recover_pc, 32'h90);
    tick();

    // Wrap of +4 at top of address space; not-taken miss must not allocate
    applyStimulus(32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h10);
    checkOutput("wrap_next_pc", pred_next_pc, 32'h0);
    checkOutput("wrap_recover", recover_pc, 32'h0);
    checkOutput("wrap_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    applyStimulus(32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    checkOutput("wrap_no_alloc", {31'd0, pred_taken}, 32'd0);
    checkOutput("invalid_mispredict", {31'd0, mispredict}, 32'd0);
    checkOutput("final_branches", stat_branches, 32'd11);
    checkOutput("final_mispredicts", stat_mispredicts, 32'd8);

    // Reset together with a resolving branch: reset wins
    reset = 1'b1;
    applyStimulus(32'h48, 1'b1, 32'h48, 1'b0, 32'h4C, 1'b1, 32'h300);
    tick();
    reset = 1'b0;
    applyStimulus(32'h48, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst2_branches", stat_branches, 32'd0);
    checkOutput("rst2_mispredicts", stat_mispredicts, 32'd0);
    checkOutput("rst2_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("rst2_next_pc", pred_next_pc, 32'h4C);
    applyStimulus(32'h88, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst2_88_next_pc", pred_next_pc, 32'h8C);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
